// File: rtl/bram_fifo_reader.sv
// bram_fifo_reader: read-domain controller for the dual-clock FIFO's RAM store.
// It issues RAM reads while the synchronized write pointer is ahead of the read
// pointer. Returned words are kept in a 2-entry buffer that feeds a valid/ready
// stream. The credit check accounts for the 1-cycle RAM latency, so the buffer
// cannot overflow while one word per cycle is sustained.
// Optional feature: define BRAM_FIFO_RD_CNT_EN to add the rd_count pop counter.
module bram_fifo_reader #(
    parameter int  DEPTH  = 16,
    parameter int  DWIDTH = 32,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic [AWIDTH:0]   wr_ptr,
    output logic [AWIDTH:0]   rd_ptr,
    output logic              ren,
    output logic [AWIDTH-1:0] raddr,
    input  logic              rdv,
    input  logic [DWIDTH-1:0] rdata,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    input  logic              m_ready,
    input  logic              flush,
    output logic              empty
`ifdef BRAM_FIFO_RD_CNT_EN
    ,
    output logic [31:0]       rd_count
`endif
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state;
    logic [1:0]        occ;
    logic [2:0]        credit;
    logic [DWIDTH-1:0] tail;
    logic              inflight;
    logic              drop;
    logic              pop;
    logic              avail;
    logic              capture;

    assign pop     = m_valid & m_ready;
    assign avail   = (wr_ptr != rd_ptr);
    assign capture = rdv & ~drop;
    assign raddr   = rd_ptr[AWIDTH-1:0];

    // Map the buffer state to an occupancy count for the credit check.
    always_comb begin
        occ = 2'd0;
        case (state)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // Slots that are committed after this edge: buffered + returning - leaving.
    // A pop always has occ >= 1, so the result cannot go negative.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign ren    = avail & ~flush & ~rst & (credit < 3'd2);
    assign empty  = (wr_ptr == rd_ptr) & (occ == 2'd0) & ~inflight;

    // Pointer, in-flight tracking and the 2-entry buffer FSM.
    // m_data is the head register itself.
    always_ff @(posedge rclk) begin
        if (rst) begin
            state    <= EMPTY;
            m_valid  <= 1'b0;
            m_data   <= '0;
            tail     <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= ren;
            // The RAM returns a word only for a read from the previous cycle.
            // Arm drop so that no returning word can land after a flush.
            drop     <= flush & inflight;
            if (flush) begin
                rd_ptr  <= wr_ptr;
                state   <= EMPTY;
                m_valid <= 1'b0;
            end else begin
                if (ren)
                    rd_ptr <= rd_ptr + (AWIDTH+1)'(1);
                case (state)
                    EMPTY: begin
                        if (capture) begin
                            m_data  <= rdata;
                            state   <= ONE;
                            m_valid <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (capture && pop) begin
                            m_data <= rdata;
                        end else if (capture) begin
                            tail  <= rdata;
                            state <= TWO;
                        end else if (pop) begin
                            state   <= EMPTY;
                            m_valid <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            m_data <= tail;
                            if (capture)
                                tail <= rdata;
                            else
                                state <= ONE;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        m_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A word returning into a full buffer with no pop means the credit rule was broken.
    a_no_overflow: assert property (@(posedge rclk) disable iff (rst)
        !(capture && !flush && state == TWO && !pop));

`ifdef BRAM_FIFO_RD_CNT_EN
    // Count accepted output words. The count saturates and is never wrapped.
    always_ff @(posedge rclk) begin
        if (rst)
            rd_count <= '0;
        else if (pop && rd_count != 32'hFFFF_FFFF)
            rd_count <= rd_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bram_fifo_reader.sv
// Bench for bram_fifo_reader: RAM model with 1-cycle latency, a queue-based
// model of the expected output stream, and directed scenarios with literal checks.
module tb_bram_fifo_reader;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          rclk = 1'b0;
    logic          rst;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          rdv = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          flush;
    logic          empty;
`ifdef BRAM_FIFO_RD_CNT_EN
    logic [31:0]   rd_count;
`endif

    always #5 rclk = ~rclk;

    bram_fifo_reader #(.DEPTH(DEPTH), .DWIDTH(DW)) dut (
        .rclk(rclk), .rst(rst), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .ren(ren),
        .raddr(raddr), .rdv(rdv), .rdata(rdata), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .flush(flush), .empty(empty)
`ifdef BRAM_FIFO_RD_CNT_EN
        , .rd_count(rd_count)
`endif
    );

    // RAM model: registered read, data valid one cycle after ren.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge rclk) begin
        rdv   <= ren;
        rdata <= mem[raddr];
    end

    int errors = 0;
    int checks = 0;

    // Stream model: every word the writer exposes is expected in pointer order; flush discards all.
    logic [DW-1:0] expq [$];
    logic [AW:0]   mdl_wr;

    task automatic set_wr(input logic [AW:0] nw);
        while (mdl_wr != nw) begin
            expq.push_back(mem[mdl_wr[AW-1:0]]);
            mdl_wr = mdl_wr + 1'b1;
        end
        wr_ptr = nw;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    // Per-scenario statistics gathered by the monitor.
    int            cyc = 0;
    int            ren_cnt, pop_cnt, first_ren, last_ren, first_pop, last_pop;
    logic [DW-1:0] first_data, last_data;
    int            raddr_log [$];
    int            rdptr_log [$];
    logic          prev_ren = 1'b0, prev_hold = 1'b0, prev_flush = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic clear_stats();
        ren_cnt = 0; pop_cnt = 0; first_ren = -1; last_ren = -1;
        first_pop = -1; last_pop = -1; first_data = '0; last_data = '0;
        raddr_log.delete(); rdptr_log.delete();
    endtask

    // Compare process: checks the DUT stream against the model every cycle.
    always @(negedge rclk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            prev_hold = 1'b0;
            prev_ren  = 1'b0;
        end else begin
            if (m_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_spurious: m_valid=1 data=0x%0h, model expects no word", m_data);
                end
            end
            if (prev_hold && m_valid && !prev_flush) begin
                checks++;
                if (m_data !== prev_data) begin
                    errors++;
                    $display("FAIL sb_hold: m_data=0x%0h expected held 0x%0h", m_data, prev_data);
                end
            end
            if (m_valid && m_ready && expq.size() > 0) begin
                logic [DW-1:0] e;
                e = expq.pop_front();
                checks++;
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: m_data=0x%0h expected 0x%0h", m_data, e);
                end
                if (first_pop < 0) begin first_pop = cyc; first_data = m_data; end
                last_pop  = cyc;
                last_data = m_data;
                pop_cnt++;
            end
            if (prev_ren) rdptr_log.push_back(int'(rd_ptr));
            if (ren) begin
                if (first_ren < 0) first_ren = cyc;
                last_ren = cyc;
                ren_cnt++;
                raddr_log.push_back(int'(raddr));
            end
            if (flush) expq.delete();
            prev_ren   = ren;
            prev_hold  = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_flush = flush;
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0; mdl_wr = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_stats();
        tick(2);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("rst_ren", ren, 0);
            chk("rst_mvalid", m_valid, 0);
            chk("rst_empty", empty, 1);
            chk("rst_rdptr", rd_ptr, 0);
        end
`ifdef BRAM_FIFO_RD_CNT_EN
        chk("rst_count", rd_count, 0);
`endif

        // Full burst at full throughput.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA0 + i;
        clear_stats();
        m_ready = 1'b1;
        set_wr(5'd16);
        tick(25);
        chk("burst_ren_cnt", ren_cnt, 16);
        chk("burst_ren_span", last_ren - first_ren, 15);
        chk("burst_latency", first_pop - first_ren, 2);
        chk("burst_pop_cnt", pop_cnt, 16);
        chk("burst_pop_span", last_pop - first_pop, 15);
        chk("burst_first", first_data, 32'hA0);
        chk("burst_last", last_data, 32'hAF);
        chk("burst_rdptr", rd_ptr, 16);
        chk("burst_empty", empty, 1);

        // Backpressure: only two reads until the consumer accepts.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hB0 + i;
        clear_stats();
        m_ready = 1'b0;
        set_wr(5'd0);
        tick(8);
        chk("bp_ren_cnt", ren_cnt, 2);
        chk("bp_mvalid", m_valid, 1);
        chk("bp_head", m_data, 32'hB0);
        chk("bp_pop_cnt", pop_cnt, 0);
        m_ready = 1'b1;
        tick(25);
        chk("bp_drain_cnt", pop_cnt, 16);
        chk("bp_drain_span", last_pop - first_pop, 15);
        chk("bp_last", last_data, 32'hBF);
        chk("bp_rdptr", rd_ptr, 0);
        chk("bp_empty", empty, 1);

        // Pointer wrap: jump to 30 via flush, then read 4 words across the wrap.
        set_wr(5'd30);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("wrap_jump", rd_ptr, 30);
        mem[14] = 32'hCE; mem[15] = 32'hCF; mem[0] = 32'hC0; mem[1] = 32'hC1;
        clear_stats();
        set_wr(5'd2);
        tick(10);
        chk("wrap_ren_cnt", ren_cnt, 4);
        if (raddr_log.size() == 4 && rdptr_log.size() == 4) begin
            chk("wrap_raddr0", raddr_log[0], 14);
            chk("wrap_raddr1", raddr_log[1], 15);
            chk("wrap_raddr2", raddr_log[2], 0);
            chk("wrap_raddr3", raddr_log[3], 1);
            chk("wrap_rdptr0", rdptr_log[0], 31);
            chk("wrap_rdptr1", rdptr_log[1], 0);
            chk("wrap_rdptr2", rdptr_log[2], 1);
            chk("wrap_rdptr3", rdptr_log[3], 2);
        end else begin
            chk("wrap_log_len", raddr_log.size(), 4);
        end
        chk("wrap_pop_cnt", pop_cnt, 4);
        chk("wrap_first", first_data, 32'hCE);
        chk("wrap_last", last_data, 32'hC1);
        chk("wrap_empty", empty, 1);

        // Flush mid-stream while a read is returning.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hD0 + i;
        clear_stats();
        set_wr(5'd8);
        tick(3);
        chk("fl_pre_pop", pop_cnt, 1);
        chk("fl_pre_first", first_data, 32'hD2);
        set_wr(5'd9);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("fl_pop_in_F", pop_cnt, 2);
        chk("fl_last", last_data, 32'hD3);
        chk("fl_mvalid", m_valid, 0);
        chk("fl_rdptr", rd_ptr, 9);
        chk("fl_empty", empty, 1);
        clear_stats();
        tick(4);
        chk("fl_post_pop", pop_cnt, 0);
        chk("fl_post_ren", ren_cnt, 0);
        chk("fl_post_mvalid", m_valid, 0);

        // Pops, flush with two words buffered, more pops.
        rst = 1'b1; m_ready = 1'b0; wr_ptr = '0; mdl_wr = '0;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hE0 + i;
        clear_stats();
        m_ready = 1'b1;
        set_wr(5'd5);
        tick(10);
        chk("cnt_pop5", pop_cnt, 5);
        m_ready = 1'b0;
        set_wr(5'd10);
        tick(6);
        chk("cnt_buf_head", m_data, 32'hE5);
        chk("cnt_buf_ren", ren_cnt, 7);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        set_wr(5'd13);
        m_ready = 1'b1;
        tick(8);
        chk("cnt_pop8", pop_cnt, 8);
        chk("cnt_last", last_data, 32'hEC);
`ifdef BRAM_FIFO_RD_CNT_EN
        chk("cnt_rd_count", rd_count, 8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
